// File: rtl/frame_buf_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_ctrl_if
// Description : Pixel-in, BRAM and stream-out signals of the ping-pong
//               frame-buffer controller. master = controller side,
//               slave = camera / BRAM / consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_buf_ctrl_if #(
   parameter int WIDTH   = 11,
   parameter int FRAME_W = 160,
   parameter int FRAME_H = 140
);
   localparam int NPIX = FRAME_W * FRAME_H;
   localparam int AW   = $clog2(2 * NPIX);

   logic             i_sof;
   logic             i_pix_valid;
   logic [WIDTH-1:0] i_pix_data;
   logic             o_bram_en;
   logic             o_wr;
   logic [AW-1:0]    o_wr_addr;
   logic [WIDTH-1:0] o_bram_wdata;
   logic             o_rd;
   logic [AW-1:0]    o_rd_addr;
   logic [WIDTH-1:0] i_bram_rdata;
   logic             i_rd_start;
   logic             o_rd_valid;
   logic             i_rd_ready;
   logic [WIDTH-1:0] o_rd_data;
   logic             o_rd_last;
   logic             o_frame_avail;
   logic             o_rd_busy;
   logic [7:0]       o_drop_cnt;
   logic [7:0]       o_short_cnt;

   modport master (
      input  i_sof, i_pix_valid, i_pix_data, i_bram_rdata, i_rd_start, i_rd_ready,
      output o_bram_en, o_wr, o_wr_addr, o_bram_wdata, o_rd, o_rd_addr,
             o_rd_valid, o_rd_data, o_rd_last, o_frame_avail, o_rd_busy,
             o_drop_cnt, o_short_cnt
   );

   modport slave (
      output i_sof, i_pix_valid, i_pix_data, i_bram_rdata, i_rd_start, i_rd_ready,
      input  o_bram_en, o_wr, o_wr_addr, o_bram_wdata, o_rd, o_rd_addr,
             o_rd_valid, o_rd_data, o_rd_last, o_frame_avail, o_rd_busy,
             o_drop_cnt, o_short_cnt
   );
endinterface
`default_nettype wire

// File: rtl/frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_ctrl
// Description : Ping-pong frame-buffer controller. The writer fills the free
//               bank, the reader streams the latest committed bank through a
//               2-entry output FIFO; whole frames are dropped when no bank
//               is free.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buf_ctrl #(
   parameter int WIDTH   = 11,
   parameter int FRAME_W = 160,
   parameter int FRAME_H = 140
) (
   input  wire logic        i_clk,
   input  wire logic        i_rst,
   frame_buf_ctrl_if.master bus
);
   localparam int            NPIX     = FRAME_W * FRAME_H;
   localparam int            AW       = $clog2(2 * NPIX);
   localparam logic [AW-1:0] NPIX_A   = AW'(NPIX);
   localparam logic [AW-1:0] LAST_OFF = AW'(NPIX - 1);

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_WRITE = 2'd1, W_DROP = 2'd2} wstate_t;
   typedef enum logic       {R_IDLE = 1'b0, R_ACTIVE = 1'b1} rstate_t;

   wstate_t          wstate, wstate_nx;
   rstate_t          rstate, rstate_nx;
   logic [AW-1:0]    wcnt, wcnt_nx, wr_off;
   logic             wr_en, commit, drop_inc, short_inc, sof_v;
   logic             latest, pend, avail;
   logic             latest_nx, pend_nx, avail_nx;
   logic [AW-1:0]    rcnt, rcnt_nx, rd_off;
   logic             rb, rb_sel, issue, start;
   logic             inflight, inflight_last;
   logic [WIDTH-1:0] fifo_data [2];
   logic [1:0]       fifo_last;
   logic             fifo_wp, fifo_rp;
   logic [1:0]       fifo_cnt;
   logic             pop, finish;
   logic [7:0]       drop_cnt, short_cnt;

   function automatic logic [AW-1:0] base(input logic bank);
      return bank ? NPIX_A : '0;
   endfunction

   assign sof_v  = bus.i_sof & bus.i_pix_valid;
   assign pop    = (fifo_cnt != 2'd0) & bus.i_rd_ready;
   assign finish = pop & fifo_last[fifo_rp];

   // Writer: next state, write offset and frame events
   always_comb begin
      wstate_nx = wstate;
      wcnt_nx   = wcnt;
      wr_off    = wcnt;
      wr_en     = 1'b0;
      commit    = 1'b0;
      drop_inc  = 1'b0;
      short_inc = 1'b0;
      case (wstate)
         W_IDLE, W_DROP: begin
            if (sof_v) begin
               // a pending frame means the only free bank is still unread
               if (pend && (rstate != R_IDLE)) begin
                  wstate_nx = W_DROP;
                  drop_inc  = 1'b1;
               end else begin
                  wr_en     = 1'b1;
                  wr_off    = '0;
                  wcnt_nx   = AW'(1);
                  wstate_nx = W_WRITE;
               end
            end
         end
         W_WRITE: begin
            if (bus.i_pix_valid) begin
               wr_en = 1'b1;
               if (bus.i_sof) begin
                  short_inc = 1'b1;
                  wr_off    = '0;
                  wcnt_nx   = AW'(1);
               end else if (wcnt == LAST_OFF) begin
                  commit    = 1'b1;
                  wcnt_nx   = '0;
                  wstate_nx = W_IDLE;
               end else begin
                  wcnt_nx = wcnt + AW'(1);
               end
            end
         end
         default: wstate_nx = W_IDLE;
      endcase
   end

   // Bank ownership: commit flips unless the reader still holds the bank
   always_comb begin
      latest_nx = latest;
      pend_nx   = pend;
      avail_nx  = avail;
      if (commit) begin
         avail_nx = 1'b1;
         if ((rstate == R_IDLE) || finish) begin
            latest_nx = ~latest;
            pend_nx   = 1'b0;
         end else begin
            pend_nx = 1'b1;
         end
      end else if (finish && pend) begin
         latest_nx = ~latest;
         pend_nx   = 1'b0;
      end
   end

   // Reader: start, read issue with FIFO space accounting, finish
   always_comb begin
      rstate_nx = rstate;
      rcnt_nx   = rcnt;
      rb_sel    = rb;
      rd_off    = rcnt;
      issue     = 1'b0;
      start     = 1'b0;
      case (rstate)
         R_IDLE: begin
            if (bus.i_rd_start && avail && !i_rst) begin
               // first read goes out in the start cycle to hit 2-cycle latency
               start     = 1'b1;
               rstate_nx = R_ACTIVE;
               rb_sel    = latest_nx;
               rd_off    = '0;
               issue     = 1'b1;
               rcnt_nx   = AW'(1);
            end
         end
         R_ACTIVE: begin
            // the slot freed by this cycle's pop is reusable immediately
            issue = ((({1'b0, fifo_cnt} + {2'b00, inflight}) - {2'b00, pop}) < 3'd2)
                    && (rcnt < NPIX_A) && !i_rst;
            if (issue)  rcnt_nx   = rcnt + AW'(1);
            if (finish) rstate_nx = R_IDLE;
         end
         default: rstate_nx = R_IDLE;
      endcase
   end

   // Writer state, bank flags and saturating counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wstate    <= W_IDLE;
         wcnt      <= '0;
         latest    <= 1'b0;
         pend      <= 1'b0;
         avail     <= 1'b0;
         drop_cnt  <= 8'd0;
         short_cnt <= 8'd0;
      end else begin
         wstate <= wstate_nx;
         wcnt   <= wcnt_nx;
         latest <= latest_nx;
         pend   <= pend_nx;
         avail  <= avail_nx;
         if (drop_inc && (drop_cnt != 8'hFF))   drop_cnt  <= drop_cnt + 8'd1;
         if (short_inc && (short_cnt != 8'hFF)) short_cnt <= short_cnt + 8'd1;
      end
   end

   // Reader state, read bank latch and in-flight read tracking
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rstate        <= R_IDLE;
         rcnt          <= '0;
         rb            <= 1'b0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
      end else begin
         rstate        <= rstate_nx;
         rcnt          <= rcnt_nx;
         if (start) rb <= rb_sel;
         inflight      <= issue;
         inflight_last <= issue && (rd_off == LAST_OFF);
      end
   end

   // Output FIFO: capture returning BRAM data, advance on handshake
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last    <= 2'b00;
         fifo_wp      <= 1'b0;
         fifo_rp      <= 1'b0;
         fifo_cnt     <= 2'd0;
      end else begin
         if (inflight) begin
            fifo_data[fifo_wp] <= bus.i_bram_rdata;
            fifo_last[fifo_wp] <= inflight_last;
            fifo_wp            <= ~fifo_wp;
         end
         if (pop) fifo_rp <= ~fifo_rp;
         fifo_cnt <= (fifo_cnt + {1'b0, inflight}) - {1'b0, pop};
      end
   end

   assign bus.o_wr          = wr_en & ~i_rst;
   assign bus.o_bram_en     = bus.o_wr;
   assign bus.o_wr_addr     = bus.o_wr ? (base(~latest) + wr_off) : '0;
   assign bus.o_bram_wdata  = bus.o_wr ? bus.i_pix_data : '0;
   assign bus.o_rd          = issue;
   assign bus.o_rd_addr     = issue ? (base(rb_sel) + rd_off) : '0;
   assign bus.o_rd_valid    = (fifo_cnt != 2'd0);
   assign bus.o_rd_data     = (fifo_cnt != 2'd0) ? fifo_data[fifo_rp] : '0;
   assign bus.o_rd_last     = (fifo_cnt != 2'd0) & fifo_last[fifo_rp];
   assign bus.o_frame_avail = avail;
   assign bus.o_rd_busy     = (rstate != R_IDLE);
   assign bus.o_drop_cnt    = drop_cnt;
   assign bus.o_short_cnt   = short_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buf_ctrl
// Description : Self-checking bench for frame_buf_ctrl (4x2 frames) with a
//               frame-level reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_buf_ctrl;
   localparam int WIDTH   = 11;
   localparam int FRAME_W = 4;
   localparam int FRAME_H = 2;
   localparam int NPIX    = FRAME_W * FRAME_H;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   frame_buf_ctrl_if #(.WIDTH(WIDTH), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H)) bus ();

   frame_buf_ctrl #(.WIDTH(WIDTH), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // BRAM: synchronous write, one-cycle registered read
   logic [WIDTH-1:0] mem [2*NPIX];
   always @(posedge clk) begin
      if (bus.o_wr) mem[bus.o_wr_addr] <= bus.o_bram_wdata;
      if (bus.o_rd) bus.i_bram_rdata   <= mem[bus.o_rd_addr];
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   int m_l, m_p, m_avail, m_ws, m_woff, m_rbusy, m_rb;
   int m_issued, m_popped, m_age, m_allrdy, m_drop, m_short;
   int m_bank [2][NPIX];
   int m_rexp [NPIX];
   int prev_stall, prev_data, prev_last;
   int wr_log[$];
   int rd_addr_log[$];
   int got_log[$];
   int lat;

   always @(negedge clk) begin : model
      int sofv, exp_wr, off, commit_ev, finish_ev, start_ev, hs, was_busy;
      if (rst) begin
         m_l = 0; m_p = 0; m_avail = 0; m_ws = 0; m_woff = 0; m_rbusy = 0; m_rb = 0;
         m_issued = 0; m_popped = 0; m_age = 0; m_allrdy = 0; m_drop = 0; m_short = 0;
         prev_stall = 0; prev_data = 0; prev_last = 0;
      end else begin
         chk("rd_busy", bus.o_rd_busy, m_rbusy);
         chk("frame_avail", bus.o_frame_avail, m_avail);
         chk("drop_cnt", bus.o_drop_cnt, m_drop);
         chk("short_cnt", bus.o_short_cnt, m_short);

         // writer: frame boundaries from sof, drop when both banks are claimed
         sofv = bus.i_sof && bus.i_pix_valid;
         exp_wr = 0; off = 0; commit_ev = 0;
         if (m_ws != 1) begin
            if (sofv) begin
               if (m_p != 0 && m_rbusy != 0) begin
                  m_ws = 2;
                  if (m_drop < 255) m_drop++;
               end else begin
                  exp_wr = 1; off = 0; m_woff = 1; m_ws = 1;
               end
            end
         end else if (bus.i_pix_valid) begin
            exp_wr = 1;
            if (bus.i_sof) begin
               if (m_short < 255) m_short++;
               off = 0; m_woff = 1;
            end else begin
               off = m_woff;
               if (m_woff == NPIX - 1) begin
                  commit_ev = 1; m_ws = 0; m_woff = 0;
               end else m_woff++;
            end
         end
         chk("wr", bus.o_wr, exp_wr);
         chk("bram_en", bus.o_bram_en, exp_wr);
         if (exp_wr != 0) begin
            chk("wr_addr", bus.o_wr_addr, (m_l != 0 ? 0 : NPIX) + off);
            chk("wdata", bus.o_bram_wdata, bus.i_pix_data);
            m_bank[1-m_l][off] = bus.i_pix_data;
         end
         if (bus.o_wr) wr_log.push_back(bus.o_wr_addr);

         // reader stream: every pixel of the latched frame, in order, once
         hs = bus.o_rd_valid && bus.i_rd_ready;
         finish_ev = 0;
         was_busy = m_rbusy;
         if (m_rbusy == 0) begin
            chk("rd_valid_idle", bus.o_rd_valid, 0);
         end else begin
            if (m_allrdy != 0) chk("rd_valid_stream", bus.o_rd_valid, (m_age >= 2) ? 1 : 0);
            if (prev_stall != 0) begin
               chk("stall_valid", bus.o_rd_valid, 1);
               chk("stall_data", bus.o_rd_data, prev_data);
               chk("stall_last", bus.o_rd_last, prev_last);
            end
            if (hs) begin
               if (m_popped < NPIX) begin
                  chk("rd_data", bus.o_rd_data, m_rexp[m_popped]);
                  chk("rd_last", bus.o_rd_last, (m_popped == NPIX - 1) ? 1 : 0);
               end else chk("rd_overrun", bus.o_rd_valid, 0);
               if (m_popped == 0) lat = m_age;
               got_log.push_back(bus.o_rd_data);
               m_popped++;
               if (m_popped == NPIX) finish_ev = 1;
            end
         end
         prev_stall = (m_rbusy != 0 && bus.o_rd_valid && !bus.i_rd_ready) ? 1 : 0;
         prev_data  = bus.o_rd_data;
         prev_last  = bus.o_rd_last;

         start_ev = (m_rbusy == 0 && bus.i_rd_start && m_avail != 0) ? 1 : 0;
         if (commit_ev != 0) begin
            m_avail = 1;
            if (m_rbusy == 0 || finish_ev != 0) begin m_l = 1 - m_l; m_p = 0; end
            else m_p = 1;
         end else if (finish_ev != 0 && m_p != 0) begin
            m_l = 1 - m_l; m_p = 0;
         end
         if (finish_ev != 0) m_rbusy = 0;
         if (start_ev != 0) begin
            m_rb = m_l; m_rbusy = 1; m_issued = 0; m_popped = 0; m_age = 0;
            m_allrdy = 1;
            for (int k = 0; k < NPIX; k++) m_rexp[k] = m_bank[m_l][k];
         end

         if (was_busy == 0 && start_ev == 0) chk("rd_spurious", bus.o_rd, 0);
         else if (bus.o_rd) begin
            chk("rd_addr", bus.o_rd_addr, (m_rb != 0 ? NPIX : 0) + m_issued);
            m_issued++;
            chk("rd_outstanding", (m_issued - m_popped <= 2) ? 1 : 0, 1);
            chk("rd_issue_bound", (m_issued <= NPIX) ? 1 : 0, 1);
         end
         if (bus.o_rd) rd_addr_log.push_back(bus.o_rd_addr);

         if (m_rbusy != 0) begin
            if (!bus.i_rd_ready) m_allrdy = 0;
            m_age++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.i_sof = 1'b0; bus.i_pix_valid = 1'b0; bus.i_pix_data = '0; bus.i_rd_start = 1'b0;
      repeat (n) tick();
   endtask

   task automatic frame(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         bus.i_sof = (i == 0); bus.i_pix_valid = 1'b1; bus.i_pix_data = WIDTH'(first + i);
         tick();
      end
      bus.i_sof = 1'b0; bus.i_pix_valid = 1'b0; bus.i_pix_data = '0;
   endtask

   task automatic start_rd();
      bus.i_rd_start = 1'b1;
      tick();
      bus.i_rd_start = 1'b0;
   endtask

   task automatic wait_rd_done(input string name, input int toggle);
      int k = 0;
      while (bus.o_rd_busy && k < 40) begin
         if (toggle != 0) bus.i_rd_ready = ~bus.i_rd_ready;
         tick();
         k++;
      end
      chk(name, bus.o_rd_busy, 0);
   endtask

   task automatic chk_q(input string name, input int q[$], input int first);
      chk({name, "_len"}, q.size(), NPIX);
      for (int i = 0; i < q.size() && i < NPIX; i++) chk(name, q[i], first + i);
   endtask

   task automatic clear_logs();
      wr_log.delete(); rd_addr_log.delete(); got_log.delete(); lat = -1;
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_wr"}, bus.o_wr, 0);
      chk({name, "_bram_en"}, bus.o_bram_en, 0);
      chk({name, "_wr_addr"}, bus.o_wr_addr, 0);
      chk({name, "_wdata"}, bus.o_bram_wdata, 0);
      chk({name, "_rd"}, bus.o_rd, 0);
      chk({name, "_rd_addr"}, bus.o_rd_addr, 0);
      chk({name, "_rd_valid"}, bus.o_rd_valid, 0);
      chk({name, "_rd_data"}, bus.o_rd_data, 0);
      chk({name, "_rd_last"}, bus.o_rd_last, 0);
      chk({name, "_avail"}, bus.o_frame_avail, 0);
      chk({name, "_busy"}, bus.o_rd_busy, 0);
      chk({name, "_drop"}, bus.o_drop_cnt, 0);
      chk({name, "_short"}, bus.o_short_cnt, 0);
   endtask

   int exp5 [13] = '{8, 9, 10, 11, 12, 8, 9, 10, 11, 12, 13, 14, 15};

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.i_sof = 1'b0; bus.i_pix_valid = 1'b0; bus.i_pix_data = '0;
      bus.i_rd_start = 1'b0; bus.i_rd_ready = 1'b0;
      lat = -1;
      repeat (3) tick();
      rst = 1'b0;
      chk_zero("reset");

      // 1: first frame lands in bank 1 and becomes available
      clear_logs();
      frame(1, NPIX);
      idle(1);
      chk_q("s1_wr_addr", wr_log, 8);
      chk("s1_avail", bus.o_frame_avail, 1);
      chk("s1_drop", bus.o_drop_cnt, 0);

      // 2: full-rate readout
      clear_logs();
      bus.i_rd_ready = 1'b1;
      start_rd();
      wait_rd_done("s2_done", 0);
      chk_q("s2_rd_addr", rd_addr_log, 8);
      chk_q("s2_data", got_log, 1);
      chk("s2_latency", lat, 2);

      // 3: readout with toggling ready
      clear_logs();
      bus.i_rd_ready = 1'b1;
      start_rd();
      wait_rd_done("s3_done", 1);
      chk_q("s3_data", got_log, 1);

      // 4: stalled reader, frame B pending, frame C dropped
      clear_logs();
      bus.i_rd_ready = 1'b0;
      start_rd();
      frame(21, NPIX);
      idle(1);
      wr_log.delete();
      frame(31, NPIX);
      idle(1);
      chk("s4_drop", bus.o_drop_cnt, 1);
      chk("s4_no_writes", wr_log.size(), 0);
      chk("s4_busy", bus.o_rd_busy, 1);
      bus.i_rd_ready = 1'b1;
      wait_rd_done("s4_done", 0);
      chk_q("s4_old_data", got_log, 1);
      clear_logs();
      start_rd();
      wait_rd_done("s4b_done", 0);
      chk_q("s4b_rd_addr", rd_addr_log, 0);
      chk_q("s4b_data", got_log, 21);

      // 5: short frame restarted by an early sof
      clear_logs();
      frame(41, 5);
      frame(51, NPIX);
      idle(1);
      chk("s5_short", bus.o_short_cnt, 1);
      chk("s5_wr_len", wr_log.size(), 13);
      for (int i = 0; i < wr_log.size() && i < 13; i++) chk("s5_wr_addr", wr_log[i], exp5[i]);
      clear_logs();
      start_rd();
      wait_rd_done("s5_done", 0);
      chk_q("s5_rd_addr", rd_addr_log, 8);
      chk_q("s5_data", got_log, 51);

      // 6: reset mid-write, then mid-read
      frame(81, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_zero("s6a");
      clear_logs();
      frame(61, NPIX);
      idle(1);
      chk_q("s6_wr_addr", wr_log, 8);
      chk("s6_avail", bus.o_frame_avail, 1);
      bus.i_rd_ready = 1'b0;
      start_rd();
      idle(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_zero("s6b");
      clear_logs();
      frame(71, NPIX);
      idle(1);
      chk_q("s6c_wr_addr", wr_log, 8);
      bus.i_rd_ready = 1'b1;
      start_rd();
      wait_rd_done("s6c_done", 0);
      chk_q("s6c_rd_addr", rd_addr_log, 8);
      chk_q("s6c_data", got_log, 71);
      chk("s6c_latency", lat, 2);

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/frame_buf_ctrl.md
Name: frame_buf_ctrl

Overview:
- Single-clock ping-pong frame-buffer controller sitting between the camera pixel stream and the dual-port pixel BRAM (WIDTH-bit words, one-cycle registered read).
- Writer fills one bank while the reader streams the most recently completed frame from the other bank to a downstream consumer over a valid/ready interface.
- Arbitrates bank ownership so the frame being read is never overwritten. Drops whole frames when no bank is free.

Parameters:
- WIDTH, 11, pixel word width.
- FRAME_W, 160, pixels per line.
- FRAME_H, 140, lines per frame.
- NPIX (local), FRAME_W*FRAME_H, pixels per frame.
- AW (local), $clog2(2*NPIX), BRAM address width. Bank 0 base is 0; bank 1 base is NPIX.

Ports:
- i_clk, in, 1: clock for all logic and both BRAM ports.
- i_rst, in, 1: synchronous reset, active-high.
- i_sof, in, 1: start of frame; qualified by i_pix_valid; marks the first pixel.
- i_pix_valid, in, 1: pixel strobe.
- i_pix_data, in, WIDTH: pixel.
- o_bram_en, out, 1: BRAM write-port enable.
- o_wr, out, 1: BRAM write strobe.
- o_wr_addr, out, AW: BRAM write address.
- o_bram_wdata, out, WIDTH: BRAM write data.
- o_rd, out, 1: BRAM read strobe.
- o_rd_addr, out, AW: BRAM read address.
- i_bram_rdata, in, WIDTH: BRAM read data, valid one cycle after o_rd.
- i_rd_start, in, 1: request readout of the latest complete frame.
- o_rd_valid, out, 1: output pixel valid.
- i_rd_ready, in, 1: consumer ready.
- o_rd_data, out, WIDTH: output pixel.
- o_rd_last, out, 1: marks the last pixel of the readout.
- o_frame_avail, out, 1: at least one frame has been committed since reset.
- o_rd_busy, out, 1: reader is active.
- o_drop_cnt, out, 8: frames dropped; saturating.
- o_short_cnt, out, 8: frames aborted by an early i_sof; saturating.

Behaviour:
- Reset values: every output is 0. Latest bank L=0. Pending flag P=0. Writer is in W_IDLE, reader is in R_IDLE. Output buffer is empty and any in-flight read is discarded. Reset mid-frame aborts everything silently; no counter increments.
- Write path is combinational pass-through:
  - o_wr = o_bram_en = (state W_WRITE, or entering it) & i_pix_valid.
  - o_wr_addr = base(~L) + wcnt.
  - o_bram_wdata = i_pix_data.
- Writer FSM:
  - W_IDLE: i_sof & i_pix_valid. If P=1 and reader busy, go to W_DROP and increment o_drop_cnt. Otherwise write pixel 0, set wcnt=1, go to W_WRITE. Valid pixels without i_sof are ignored.
  - W_WRITE: each valid pixel is written and wcnt increments.
    - The pixel with wcnt=NPIX-1 commits the frame and returns to W_IDLE.
    - i_sof & i_pix_valid before completion: increment o_short_cnt, restart the new frame at wcnt=0 in the same bank, and write that pixel at offset 0.
  - W_DROP: ignore pixels. The next i_sof is re-evaluated exactly as in W_IDLE.
- Commit:
  - Reader not busy: L<=~L, P=0, o_frame_avail<=1.
  - Reader busy: P<=1 and L is unchanged.
  - "Busy" excludes a reader finishing in the same cycle. Commit and reader finish in the same cycle therefore flips L directly.
- Reader finish with P=1: L<=~L, P<=0.
- Reader FSM:
  - R_IDLE: i_rd_start & o_frame_avail latches read bank rb = L after this cycle's commit/flip update, sets rcnt=0, goes to R_ACTIVE. If o_frame_avail=0, i_rd_start is ignored.
  - R_ACTIVE: issue o_rd with o_rd_addr = base(rb)+rcnt whenever (buffered + in-flight) < 2 and rcnt < NPIX; rcnt increments on issue.
  - i_bram_rdata is captured into a 2-entry FIFO one cycle after o_rd.
  - o_rd_valid = FIFO not empty; o_rd_data = FIFO head. No bubble under continuous i_rd_ready: one pixel per cycle after 2-cycle start latency (i_rd_start to first o_rd_valid).
  - o_rd_last = 1 on the head corresponding to address offset NPIX-1.
  - Handshake of the last pixel finishes the readout: return to R_IDLE and apply the pending flip. o_rd_valid/o_rd_data hold stable while i_rd_ready=0.
  - o_rd_busy = (state != R_IDLE).
- Counters saturate at 255.

Test Plan (FRAME_W=4, FRAME_H=2, NPIX=8):
- Reset, then i_sof + 8 valid pixels 1..8 → writes at addresses 8..15 (bank 1); after the 8th, L=1 and o_frame_avail=1; o_drop_cnt=0.
- i_rd_start, i_rd_ready=1 → o_rd addresses 8..15 on consecutive cycles; o_rd_data 1..8 starting 2 cycles after start; o_rd_last with data 8; o_rd_busy drops after that handshake.
- Readout with i_rd_ready toggling 1,0,1,0 → every pixel delivered exactly once in order; data stable while stalled; never more than 2 reads outstanding.
- During a slow readout, commit frame B (pending), then send i_sof for frame C → C dropped with o_drop_cnt=1 and no writes; after reader finishes, L flips to B's bank.
- i_sof after 5 pixels, then 8 more pixels → o_short_cnt=1; new frame written at offsets 0..7 of the same bank and committed.
- Assert i_rst in mid-write and mid-read → next cycle all outputs are 0, no counter change, and a subsequent full frame behaves as in scenario 1.
